tx_scheduler: RTL and testbench

//  Round-robin scheduler sharing one serial transmitter among NREQ requesters.

---
 rtl/tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_tx_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// tx_scheduler: round-robin scheduler that shares one serial transmitter among
// NREQ requesters. One requester is granted in IDLE and its byte is latched.
// The scheduler then pulses the transmitter's ld with cen high, holds cen for a
// full frame, and waits out an optional inter-frame gap.
//
// Optional feature: define HIPRI0_EN to give requester 0 strict priority.
// Requesters 1..NREQ-1 then round-robin among themselves. When HIPRI0_EN is
// undefined, round-robin covers all NREQ requesters.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   FRAME_BITS  cen-high cycles after the load cycle (1..16)
//   GAP_CYCLES  cen-low cycles between frames (0..16, 0 = back-to-back)
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous reset, active-high
//   req     in   per-requester request, held until ack
//   data    in   byte per requester, requester i at data[8i+7:8i]
//   ack     out  one-cycle pulse: request accepted, byte latched
//   ld      out  transmitter parallel load (LOAD cycle only)
//   cen     out  transmitter count/shift enable (LOAD + frame)
//   par_ld  out  byte presented to transmitter, stable until next grant
//   busy    out  high in every state except IDLE
//   gnt_id  out  index of current/last granted requester, zero-extended
module tx_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic              ld,
    output logic              cen,
    output logic [7:0]        par_ld,
    output logic              busy,
    output logic [2:0]        gnt_id
);

    // Counter reload values; the counter runs down to 0 inclusive.
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] GAP_LAST   = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_INIT  = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StGap
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [2:0]      last;
    logic [2:0]      winner;
    logic [NREQ-1:0] win_onehot;
    logic [7:0]      win_data;
    logic [7:0]      req_ext;

    assign req_ext = 8'(req);

    // First set request found while scanning from+1, from+2, ... modulo NREQ.
    // When skip0 is set, index 0 is excluded from the scan.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] from,
                                           input logic skip0);
        logic [2:0] pick;
        logic [2:0] idx;
        logic       hit;
        pick = from;
        hit  = 1'b0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = 3'((int'(from) + k) % int'(NREQ));
            if (!hit && r[idx] && !(skip0 && idx == 3'd0)) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef HIPRI0_EN
    // Requester 0 always wins; the rest share round-robin.
    assign winner = req[0] ? 3'd0 : rr_pick(req_ext, last, 1'b1);
`else
    assign winner = rr_pick(req_ext, last, 1'b0);
`endif

    // Decode the winner into an ack vector and select its byte.
    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (winner == 3'(i)) begin
                win_onehot[i] = 1'b1;
                win_data      = data[8*i +: 8];
            end
        end
    end

    // All outputs are registered and change together with the state, so each
    // output is a glitch-free decode of the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            cnt    <= '0;
            last   <= LAST_INIT;
            ack    <= '0;
            ld     <= 1'b0;
            cen    <= 1'b0;
            par_ld <= '0;
            busy   <= 1'b0;
            gnt_id <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        par_ld <= win_data;
                        gnt_id <= winner;
`ifdef HIPRI0_EN
                        // Grants to the priority requester leave the RR pointer alone.
                        if (winner != 3'd0) begin
                            last <= winner;
                        end
`else
                        last   <= winner;
`endif
                        ack    <= win_onehot;
                        ld     <= 1'b1;
                        cen    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= StLoad;
                    end
                end
                StLoad: begin
                    ack   <= '0;
                    ld    <= 1'b0;
                    cnt   <= FRAME_LAST;
                    state <= StShift;
                end
                StShift: begin
                    if (cnt == 4'd0) begin
                        cen <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            cnt   <= GAP_LAST;
                            state <= StGap;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StGap: begin
                    if (cnt == 4'd0) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler. Two instances share the stimulus: unit 0 uses a
// 2-cycle gap and unit 1 runs back-to-back. A frame-timeline reference model
// tracks each unit. The model records the cycle offset since the last load and
// the round-robin pointer, and derives the expected outputs from those.
module tb_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int FRAME = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;

    logic [3:0] ack_a, ack_b;
    logic       ld_a, ld_b, cen_a, cen_b, busy_a, busy_b;
    logic [7:0] par_a, par_b;
    logic [2:0] gnt_a, gnt_b;

    tx_scheduler #(.NREQ(NREQ), .FRAME_BITS(FRAME), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack_a), .ld(ld_a),
        .cen(cen_a), .par_ld(par_a), .busy(busy_a), .gnt_id(gnt_a)
    );

    tx_scheduler #(.NREQ(NREQ), .FRAME_BITS(FRAME), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack_b), .ld(ld_b),
        .cen(cen_b), .par_ld(par_b), .busy(busy_b), .gnt_id(gnt_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state per unit: phase = cycles since the load cycle
    // started (-1 when idle).
    int         m_phase [2];
    int         m_last  [2];
    logic [2:0] m_gnt   [2];
    logic [7:0] m_par   [2];

    function automatic int gap_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic logic [17:0] obs(input int u);
        if (u == 0) return {ack_a, ld_a, cen_a, busy_a, par_a, gnt_a};
        return {ack_b, ld_b, cen_b, busy_b, par_b, gnt_b};
    endfunction

    function automatic logic [17:0] exp_vec(input int u);
        int         p;
        logic [3:0] a;
        p = m_phase[u];
        a = (p == 0) ? 4'(1 << m_gnt[u]) : 4'b0000;
        return {a, (p == 0), (p >= 0 && p <= FRAME), (p >= 0), m_par[u], m_gnt[u]};
    endfunction

    // Winner under the scheduling rules, given the last RR grant.
    function automatic int choose(input int last, input logic [3:0] r);
        int idx;
`ifdef HIPRI0_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
`ifdef HIPRI0_EN
            if (idx == 0) continue;
`endif
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset(input int u);
        m_phase[u] = -1;
        m_last[u]  = NREQ - 1;
        m_gnt[u]   = 3'd0;
        m_par[u]   = 8'h00;
    endtask

    task automatic model_step(input int u);
        int w;
        if (m_phase[u] < 0) begin
            if (req != 4'b0000) begin
                w          = choose(m_last[u], req);
                m_gnt[u]   = 3'(w);
                m_par[u]   = data[8*w +: 8];
`ifdef HIPRI0_EN
                if (w != 0) m_last[u] = w;
`else
                m_last[u]  = w;
`endif
                m_phase[u] = 0;
            end
        end else if (m_phase[u] < FRAME + gap_of(u)) begin
            m_phase[u]++;
        end else begin
            m_phase[u] = -1;
        end
    endtask

    // Advance one clock: model follows the inputs present at the edge; return
    // 1 time unit later so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            if (rst) model_reset(u);
            else     model_step(u);
        end
        cyc++;
        #1;
    endtask

    // Requesters drop their request once acknowledged by unit u.
    task automatic drop_acked(input int u);
        logic [17:0] e;
        e   = exp_vec(u);
        req = req & ~e[17:14];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (obs(u) !== exp_vec(u)) begin
                errors++;
                $display("FAIL reset_hold u%0d got=%h exp=%h", u, obs(u), exp_vec(u));
            end
        end
        tick();
        rst  = 1'b0;
        req  = 4'b0100;
        data = $urandom();
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL reset_pre u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u),
                             exp_vec(u));
                end
            end
            drop_acked(0);
        end
        // Mid-SHIFT: reset must clear outputs without waiting for a clock edge.
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        checks++;
        if (obs(0) !== 18'h0 || obs(1) !== 18'h0) begin
            errors++;
            $display("FAIL reset_async got_a=%h got_b=%h exp=0", obs(0), obs(1));
        end
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if ({ld_a, ack_a, gnt_a} !== {1'b1, 4'b0001, 3'd0}) begin
            errors++;
            $display("FAIL reset_first_grant got ld=%b ack=%b gnt=%0d exp ld=1 ack=0001 gnt=0",
                     ld_a, ack_a, gnt_a);
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        int cen_cnt;
        do_reset();
        data = $urandom();
        data[23:16] = 8'h0D;
        req  = 4'b0100;
        tick();
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (obs(u) !== exp_vec(u)) begin
                errors++;
                $display("FAIL single_load u%0d got=%h exp=%h", u, obs(u), exp_vec(u));
            end
        end
        checks++;
        if ({ld_a, cen_a, ack_a, par_a} !== {1'b1, 1'b1, 4'b0100, 8'h0D}) begin
            errors++;
            $display("FAIL single_load_const got ld=%b cen=%b ack=%b par=%h exp 1 1 0100 0d",
                     ld_a, cen_a, ack_a, par_a);
        end
        drop_acked(0);
        cen_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            data = $urandom();
            tick();
            if (cen_a) cen_cnt++;
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL single u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u),
                             exp_vec(u));
                end
            end
        end
        checks++;
        if (cen_cnt != FRAME || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL single_frame got cen_cycles=%0d busy=%b exp %0d 0", cen_cnt, busy_a,
                     FRAME);
        end
    endtask

    task automatic test_rr_fairness();
        int ld_cyc [$];
        int ld_gnt [$];
        int acks   [4];
        int start;
        do_reset();
        data  = $urandom();
        req   = 4'b1111;
        start = cyc;
        acks  = '{0, 0, 0, 0};
        for (int i = 0; i < 5 * 14 + 2; i++) begin
            tick();
            if (ld_a) begin
                ld_cyc.push_back(cyc);
                ld_gnt.push_back(int'(gnt_a));
            end
            if (cyc - start <= 56) begin
                for (int j = 0; j < 4; j++) if (ack_a[j]) acks[j]++;
            end
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL rr u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u), exp_vec(u));
                end
            end
        end
        checks++;
        if (ld_cyc.size() < 5) begin
            errors++;
            $display("FAIL rr_count got=%0d loads exp>=5", ld_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (ld_gnt[i] != i % 4) begin
                    errors++;
                    $display("FAIL rr_order grant %0d got=%0d exp=%0d", i, ld_gnt[i], i % 4);
                end
                if (i > 0) begin
                    checks++;
                    if (ld_cyc[i] - ld_cyc[i-1] != 14) begin
                        errors++;
                        $display("FAIL rr_period got=%0d exp=14", ld_cyc[i] - ld_cyc[i-1]);
                    end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (acks[j] != 1) begin
                errors++;
                $display("FAIL rr_acks requester %0d got=%0d exp=1", j, acks[j]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_withdrawal();
        int ack1;
        int lds;
        do_reset();
        data = $urandom();
        req  = 4'b0001;
        tick();
        drop_acked(0);
        ack1 = 0;
        lds  = 0;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) req[1] = 1'b1;
            if (i == 6) req[1] = 1'b0;
            tick();
            if (ack_a[1] || ack_b[1]) ack1++;
            if (ld_a || ld_b) lds++;
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL withdraw u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u),
                             exp_vec(u));
                end
            end
        end
        checks++;
        if (ack1 != 0 || lds != 0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_idle got ack1=%0d loads=%0d busy=%b%b exp 0 0 00", ack1, lds,
                     busy_a, busy_b);
        end
    endtask

    task automatic test_back_to_back();
        int ld_cyc [$];
        int ld_gnt [$];
        do_reset();
        data = $urandom();
        req  = 4'b0011;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (ld_b) begin
                ld_cyc.push_back(cyc);
                ld_gnt.push_back(int'(gnt_b));
            end
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL b2b u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u), exp_vec(u));
                end
            end
            drop_acked(1);
        end
        checks++;
        if (ld_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got=%0d loads exp=2", ld_cyc.size());
        end else begin
            checks++;
            if (ld_cyc[1] - ld_cyc[0] != 12 || ld_gnt[0] != 0 || ld_gnt[1] != 1) begin
                errors++;
                $display("FAIL b2b_timing got spacing=%0d grants=%0d,%0d exp 12 0,1",
                         ld_cyc[1] - ld_cyc[0], ld_gnt[0], ld_gnt[1]);
            end
        end
    endtask

`ifdef HIPRI0_EN
    task automatic test_hipri();
        int ld_gnt [$];
        do_reset();
        data = $urandom();
        req  = 4'b1110;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) req[0] = 1'b1;
            tick();
            if (ld_a) ld_gnt.push_back(int'(gnt_a));
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL hipri u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u),
                             exp_vec(u));
                end
            end
            if (ack_a[0]) req[0] = 1'b0;
        end
        checks++;
        if (ld_gnt.size() < 3 || ld_gnt[0] != 1 || ld_gnt[1] != 0 || ld_gnt[2] != 2) begin
            errors++;
            $display("FAIL hipri_order got %0d grants exp order 1,0,2", ld_gnt.size());
        end
        req = 4'b0000;
    endtask
`endif

    task automatic test_random();
        logic [17:0] e;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            data = $urandom();
            tick();
            for (int u = 0; u < 2; u++) begin
                checks++;
                if (obs(u) !== exp_vec(u)) begin
                    errors++;
                    $display("FAIL random u%0d cyc=%0d got=%h exp=%h", u, cyc, obs(u),
                             exp_vec(u));
                end
            end
            e = exp_vec(0);
            for (int j = 0; j < 4; j++) begin
                if (!req[j]) begin
                    if ($urandom_range(3) == 0) req[j] = 1'b1;
                end else if (e[14+j]) begin
                    if ($urandom_range(3) != 0) req[j] = 1'b0;
                end else if ($urandom_range(31) == 0) begin
                    req[j] = 1'b0;
                end
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        data = 32'h0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single();
        test_rr_fairness();
        test_withdrawal();
        test_back_to_back();
`ifdef HIPRI0_EN
        test_hipri();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
